// File: rtl/ds2_modulator_tx.sv
// ds2_modulator_tx
// Second-order delta-sigma modulator, transmit side. It takes signed PCM
// samples over a valid/ready handshake, holds each one for OSR clocks, and
// emits one modulator bit per clock while running.
//
// Ports
//   clk        : single rising-edge clock
//   reset_n    : asynchronous active-low reset
//   enable     : run request; low returns the block to IDLE
//   din        : signed PCM sample, full scale FS = 2^(DIN_W-1)
//   din_valid  : sample offered
//   din_ready  : sample taken this cycle (combinational)
//   bit_out    : modulator bit, 1 = +FS, 0 = -FS
//   bit_valid  : bit_out valid this cycle
//   underrun   : sticky, no sample offered at a period boundary
//   overload   : sticky, an integrator saturated
//
// state | meaning
// IDLE  | integrators, phase and sticky flags cleared; waiting for a sample
// RUN   | one modulator step per clock; sample reload every OSR clocks
`timescale 1ns/1ps
module ds2_modulator_tx #(
  parameter int DIN_W = 16,
  parameter int OSR   = 64,
  parameter int INT_W = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic signed [DIN_W-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    underrun,
  output logic                    overload
);

  localparam int PH_W = $clog2(OSR);
  localparam int EW   = INT_W + 1;
  localparam logic [PH_W-1:0] LAST = PH_W'(OSR - 1);

  localparam logic signed [EW-1:0] FS_P =
    $signed({{(EW-DIN_W){1'b0}}, 1'b1, {(DIN_W-1){1'b0}}});
  localparam logic signed [EW-1:0] FS_N = -FS_P;
  localparam logic signed [INT_W-1:0] I_MAX = $signed({1'b0, {(INT_W-1){1'b1}}});
  localparam logic signed [INT_W-1:0] I_MIN = $signed({1'b1, {(INT_W-1){1'b0}}});

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic signed [DIN_W-1:0] x_reg, x_nxt;
  logic [PH_W-1:0]         phase, phase_nxt;
  logic signed [INT_W-1:0] i1, i1_nxt, i2, i2_nxt;
  logic                    bit_nxt, bv_nxt, und_nxt, ovl_nxt;

  // modulator step datapath
  logic                    v;
  logic signed [EW-1:0]    fb_e, x_e, i1_e, i2_e, diff1, diff2, s1, s2;
  logic                    clip1, clip2;
  logic signed [INT_W-1:0] i1_sat, i2_sat;

  assign din_ready = reset_n & enable & ((state == IDLE) | (phase == LAST));

  always_comb begin
    v     = ~i2[INT_W-1];
    fb_e  = v ? FS_P : FS_N;
    x_e   = {{(EW-DIN_W){x_reg[DIN_W-1]}}, x_reg};
    i1_e  = {i1[INT_W-1], i1};
    i2_e  = {i2[INT_W-1], i2};
    diff1 = x_e - fb_e;
    diff2 = i1_e - fb_e;
    s1    = i1_e + (diff1 >>> 1);
    s2    = i2_e + (diff2 >>> 1);
    // the EW-bit sums always fit; a mismatch in the two top bits means the
    // value left the INT_W range and must be clamped
    clip1  = s1[EW-1] ^ s1[EW-2];
    clip2  = s2[EW-1] ^ s2[EW-2];
    i1_sat = clip1 ? (s1[EW-1] ? I_MIN : I_MAX) : s1[INT_W-1:0];
    i2_sat = clip2 ? (s2[EW-1] ? I_MIN : I_MAX) : s2[INT_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x_reg;
    phase_nxt = phase;
    i1_nxt    = i1;
    i2_nxt    = i2;
    bit_nxt   = bit_out;
    bv_nxt    = bit_valid;
    und_nxt   = underrun;
    ovl_nxt   = overload;
    case (state)
      IDLE: begin
        i1_nxt    = '0;
        i2_nxt    = '0;
        phase_nxt = '0;
        und_nxt   = 1'b0;
        ovl_nxt   = 1'b0;
        bv_nxt    = 1'b0;
        if (din_valid && din_ready) begin
          state_nxt = RUN;
          x_nxt     = din;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
          bv_nxt    = 1'b0;
        end else begin
          i1_nxt  = i1_sat;
          i2_nxt  = i2_sat;
          bit_nxt = v;
          bv_nxt  = 1'b1;
          ovl_nxt = overload | clip1 | clip2;
          if (phase == LAST) begin
            phase_nxt = '0;
            if (din_valid) x_nxt = din;
            else           und_nxt = 1'b1;
          end else begin
            phase_nxt = phase + PH_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      x_reg     <= '0;
      phase     <= '0;
      i1        <= '0;
      i2        <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      underrun  <= 1'b0;
      overload  <= 1'b0;
    end else begin
      state     <= state_nxt;
      x_reg     <= x_nxt;
      phase     <= phase_nxt;
      i1        <= i1_nxt;
      i2        <= i2_nxt;
      bit_out   <= bit_nxt;
      bit_valid <= bv_nxt;
      underrun  <= und_nxt;
      overload  <= ovl_nxt;
    end
  end

endmodule

// File: tb/tb_ds2_modulator_tx.sv
`timescale 1ns/1ps
module tb_ds2_modulator_tx;

  localparam int DIN_W = 16;
  localparam int OSR   = 64;
  localparam int INT_W = 24;
  localparam longint FS   = 64'sd32768;
  localparam longint IMAX = (64'sd1 <<< (INT_W-1)) - 1;
  localparam longint IMIN = -(64'sd1 <<< (INT_W-1));

  logic clk, reset_n, enable, din_valid;
  logic signed [DIN_W-1:0] din;
  logic din_ready, bit_out, bit_valid, underrun, overload;

  logic o_en, o_dv;
  logic signed [DIN_W-1:0] o_din;
  logic o_rdy, o_bit, o_bv, o_und, o_ovl;

  int n_tests = 0;
  int n_fail  = 0;

  ds2_modulator_tx #(.DIN_W(DIN_W), .OSR(OSR), .INT_W(INT_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .bit_out(bit_out),
    .bit_valid(bit_valid), .underrun(underrun), .overload(overload)
  );

  ds2_modulator_tx #(.DIN_W(DIN_W), .OSR(OSR), .INT_W(20)) u_ovl (
    .clk(clk), .reset_n(reset_n), .enable(o_en), .din(o_din),
    .din_valid(o_dv), .din_ready(o_rdy), .bit_out(o_bit),
    .bit_valid(o_bv), .underrun(o_und), .overload(o_ovl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (integer arithmetic from the rules)
  bit     m_run, m_bit, m_bv, m_und, m_ovl;
  int     m_phase;
  longint m_x, m_i1, m_i2;
  logic   last_rdy;

  function automatic longint fhalf(input longint a);
    return (a - (((a % 2) + 2) % 2)) / 2;
  endfunction

  task automatic model_reset();
    m_run = 0; m_bit = 0; m_bv = 0; m_und = 0; m_ovl = 0;
    m_phase = 0; m_x = 0; m_i1 = 0; m_i2 = 0;
  endtask

  function automatic bit model_ready(input bit en);
    return en && (!m_run || m_phase == OSR-1);
  endfunction

  task automatic model_edge(input bit en, input bit dv, input longint d);
    bit     rdy, v;
    longint fb, n1, n2;
    rdy = model_ready(en);
    if (!m_run) begin
      m_i1 = 0; m_i2 = 0; m_phase = 0; m_und = 0; m_ovl = 0; m_bv = 0;
      if (rdy && dv) begin
        m_run = 1;
        m_x   = d;
      end
    end else if (!en) begin
      m_run = 0;
      m_bv  = 0;
    end else begin
      v  = (m_i2 >= 0);
      fb = v ? FS : -FS;
      n1 = m_i1 + fhalf(m_x - fb);
      n2 = m_i2 + fhalf(m_i1 - fb);
      if (n1 > IMAX) begin n1 = IMAX; m_ovl = 1; end
      if (n1 < IMIN) begin n1 = IMIN; m_ovl = 1; end
      if (n2 > IMAX) begin n2 = IMAX; m_ovl = 1; end
      if (n2 < IMIN) begin n2 = IMIN; m_ovl = 1; end
      m_i1 = n1; m_i2 = n2; m_bit = v; m_bv = 1;
      if (m_phase == OSR-1) begin
        m_phase = 0;
        if (dv) m_x = d;
        else    m_und = 1;
      end else begin
        m_phase++;
      end
    end
  endtask

  // ---------------- checking helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // drive inputs, check din_ready, advance one edge, check registered outputs
  task automatic cycle(input bit en, input bit dv, input longint d);
    enable = en; din_valid = dv; din = d[DIN_W-1:0];
    #1;
    last_rdy = din_ready;
    chk("din_ready", {31'd0, din_ready}, {31'd0, model_ready(en)});
    model_edge(en, dv, d);
    @(posedge clk); #1;
    chk("outs", {28'd0, bit_out, bit_valid, underrun, overload},
                {28'd0, m_bit, m_bv, m_und, m_ovl});
  endtask

  task automatic go_idle();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
  endtask

  typedef struct {
    longint din;
    int     exp_ones;
    int     tol;
  } dc_vec_t;

  dc_vec_t vecs[5];
  bit      pat[4];

  initial begin
    int ones, rdys, k;
    bit seen, bv_bad, x_bad, sticky_bad;

    vecs[0] = '{ 16384, 3072, 4};
    vecs[1] = '{     0, 2048, 0};
    vecs[2] = '{ -8192, 1536, 4};
    vecs[3] = '{ 24576, 3584, 8};
    vecs[4] = '{-16384, 1024, 4};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // ---- reset state: din_ready held low while in reset even with enable
    reset_n = 1'b0; enable = 1'b1; din_valid = 1'b1; din = '0;
    o_en = 1'b0; o_dv = 1'b0; o_din = '0;
    model_reset();
    #12;
    chk("reset_outs", {27'd0, din_ready, bit_out, bit_valid, underrun, overload}, 32'd0);
    enable = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("idle_rdy_en0", {31'd0, din_ready}, 32'd0);
    enable = 1'b1;
    #1;
    chk("idle_rdy_en1", {31'd0, din_ready}, 32'd1);

    // ---- zero input: latency and 1,0,0,1 pattern
    go_idle();
    cycle(1, 1, 0);
    chk("zero_lat_bv0", {31'd0, bit_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 0);
      if (i == 0) chk("zero_first_bv", {31'd0, bit_valid}, 32'd1);
      chk("zero_pattern", {31'd0, bit_out}, {31'd0, pat[i % 4]});
      if (i % 4 == 3) begin
        chk("zero_i1", u_dut.i1, 32'd0);
        chk("zero_i2", u_dut.i2, 32'd0);
      end
    end

    // ---- DC table: ones density, ready rate, no flags
    foreach (vecs[j]) begin
      go_idle();
      cycle(1, 1, vecs[j].din);
      ones = 0; rdys = 0;
      for (int i = 0; i < 4096; i++) begin
        cycle(1, 1, vecs[j].din);
        if (last_rdy === 1'b1) rdys++;
        if (bit_valid === 1'b1 && bit_out === 1'b1) ones++;
      end
      chk_range("dc_ones", ones, vecs[j].exp_ones - vecs[j].tol, vecs[j].exp_ones + vecs[j].tol);
      chk("dc_ready_count", rdys, 4096 / OSR);
      chk("dc_underrun", {31'd0, underrun}, 32'd0);
      chk("dc_overload", {31'd0, overload}, 32'd0);
    end

    // ---- underrun: one sample then no more
    go_idle();
    cycle(1, 1, -8192);
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      cycle(1, 0, 0);
      if (bit_valid === 1'b1 && bit_out === 1'b1) ones++;
      if (i == 62) chk("und_before", {31'd0, underrun}, 32'd0);
      if (i == 63) chk("und_set", {31'd0, underrun}, 32'd1);
    end
    chk_range("und_ones", ones, 1532, 1540);
    chk("und_sticky", {31'd0, underrun}, 32'd1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("und_cleared", {31'd0, underrun}, 32'd0);
    cycle(1, 0, 0);
    chk("und_after_en", {31'd0, underrun}, 32'd0);

    // ---- enable vs valid collision at a boundary
    go_idle();
    cycle(1, 1, 16384);
    for (int i = 0; i < OSR-1; i++) cycle(1, 1, 16384);
    chk("coll_phase_rdy", {31'd0, din_ready}, 32'd1);
    cycle(0, 1, 16384);
    chk("coll_rdy", {31'd0, last_rdy}, 32'd0);
    chk("coll_bv", {31'd0, bit_valid}, 32'd0);
    cycle(0, 1, 16384);
    chk("coll_bv_idle", {31'd0, bit_valid}, 32'd0);
    cycle(1, 0, 0);
    chk("coll_noacc", {31'd0, bit_valid}, 32'd0);

    // ---- mid-run asynchronous reset
    go_idle();
    cycle(1, 1, 1000);
    for (int i = 0; i < 20; i++) cycle(1, 1, 1000);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_outs", {27'd0, din_ready, bit_out, bit_valid, underrun, overload}, 32'd0);
    chk("midrst_i2", u_dut.i2, 32'd0);
    model_reset();
    @(negedge clk);
    enable = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("midrst_rdy_en0", {31'd0, din_ready}, 32'd0);
    enable = 1'b1;
    #1;
    chk("midrst_rdy_en1", {31'd0, din_ready}, 32'd1);

    // ---- randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
            longint'($urandom_range(0, 49152)) - 24576);
    end
    go_idle();

    // ---- overload with a narrow integrator
    @(posedge clk); #1;
    o_en = 1'b1; o_dv = 1'b1; o_din = 16'sd32767;
    #1;
    chk("ovl_rdy", {31'd0, o_rdy}, 32'd1);
    seen = 0; bv_bad = 0; x_bad = 0; sticky_bad = 0;
    for (k = 0; k < 2001; k++) begin
      @(posedge clk); #1;
      if (k >= 1 && o_bv !== 1'b1) bv_bad = 1;
      if ($isunknown(o_bit)) x_bad = 1;
      if (seen && o_ovl !== 1'b1) sticky_bad = 1;
      if (o_ovl === 1'b1) seen = 1;
    end
    chk("ovl_set", {31'd0, o_ovl}, 32'd1);
    chk("ovl_seen", {31'd0, seen}, 32'd1);
    chk("ovl_sticky_bad", {31'd0, sticky_bad}, 32'd0);
    chk("ovl_bv_bad", {31'd0, bv_bad}, 32'd0);
    chk("ovl_x_bad", {31'd0, x_bad}, 32'd0);
    o_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ds2_modulator_tx.md
# ds2_modulator_tx

Second-order digital delta-sigma modulator: the transmit-side counterpart of the integrator/comb/FIR decimation chain. It accepts multi-bit PCM samples over a valid/ready handshake and holds each one for OSR clocks. It emits a 1-bit oversampled bitstream with a valid strobe every cycle while running. It is used as a stimulus and loopback source for the decimator, both in silicon and in post-layout benches.

## Interface
- DIN_W, 16: signed PCM input width; full scale FS = 2^(DIN_W-1).
- OSR, 64: output bits per input sample; legal range is 2 or more.
- INT_W, 24: signed integrator width; must be at least DIN_W+4.
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; low forces IDLE.
- din  in  DIN_W  signed PCM sample.
- din_valid  in  1  sample offered.
- din_ready  out  1  block accepts `din` this cycle.
- bit_out  out  1  modulator bit: 1 means +FS, 0 means -FS.
- bit_valid  out  1  `bit_out` is valid this cycle.
- underrun  out  1  sticky: no sample was offered at a period boundary.
- overload  out  1  sticky: an integrator saturated.

## Operation
- **States.**
  - IDLE: integrators are cleared and `bit_valid` = 0.
  - RUN: one modulator step every clock.
- **Transitions.**
  - IDLE → RUN on an accepted sample (`din_valid` & `din_ready` at a clock edge). On that edge `x_reg` is loaded with `din` and `phase` is set to 0.
  - RUN → IDLE at the next edge whenever `enable` = 0.
  - In IDLE, `i1`, `i2` and `phase` are cleared. `underrun` and `overload` are cleared on that same edge.
- **din_ready.**
  - Equals `enable` & (state==IDLE | phase==OSR-1).
  - Forced to 0 while `enable` = 0. If `enable` falls while `din_valid` = 1, `enable` wins and the sample is not taken.
- **Period boundary** (in RUN, the edge where phase==OSR-1).
  - Sample accepted: load `x_reg` and wrap `phase` to 0.
  - No sample offered: keep `x_reg`, wrap `phase` to 0, and set `underrun`.
  - Otherwise `phase` increments by 1.
- **Modulator step** (every RUN cycle, using the old register values):
  - v = (i2 >= 0)
  - fb = v ? +FS : -FS
  - i1' = sat(i1 + ((x_reg - fb) >>> 1))
  - i2' = sat(i2 + ((i1 - fb) >>> 1))
  - bit_out ← v, bit_valid ← 1
- **Arithmetic.**
  - All terms are sign-extended to INT_W+1 bits before add and shift; `>>>` is an arithmetic shift.
  - sat() clamps to [-(2^(INT_W-1)), 2^(INT_W-1)-1] and sets `overload` when it clamps.
- **Stability.** Guaranteed for |din| ≤ 0.75·FS. Larger inputs are legal but may set `overload`.
- **Transfer.** Mean of the ±1 bitstream equals x_reg/FS.

## Timing
- **Reset values.** While `reset_n` = 0: `din_ready`, `bit_out`, `bit_valid`, `underrun` and `overload` are all 0; state is IDLE; `i1` = `i2` = `phase` = 0. `din_ready` rises combinationally from `enable` once `reset_n` is high.
- **Latency.** A sample accepted at edge t produces its first `bit_valid` = 1 after edge t+1, computed with that sample.
- **Sample use.** Each sample influences exactly OSR consecutive bits, except when underrun causes it to be re-used.
- **Output strobe.** `bit_valid` stays continuously high in RUN. It drops after the first edge on which IDLE is entered.
- **Back-to-back samples.** Supported with no bubbles: `din_ready` is high in exactly one of every OSR RUN cycles.
- **Mid-run reset.** Asserting `reset_n` low takes effect immediately and asynchronously. All outputs return to their reset values at once, and no partial sample is retained.
- **Outputs.** All outputs are registered except `din_ready`.

## Test plan
- **Reset and idle.**
  - Stimulus: reset mid-RUN, then release with `enable` = 0.
  - Required: all outputs 0 and `din_ready` = 0. Raising `enable` makes `din_ready` = 1 in the same cycle.
- **Zero input** (DIN_W=16, OSR=64).
  - Stimulus: accept `din` = 0.
  - Required: first `bit_valid` one cycle after acceptance; bit sequence 1,0,0,1 repeating; `i1`/`i2` return to 0 every 4 cycles.
- **DC +0.5·FS.**
  - Stimulus: keep `din` = 16384 valid, run 4096 bits.
  - Required: ones count 3072 ±4; `din_ready` high every 64th cycle; `underrun` = 0; `overload` = 0.
- **Underrun.**
  - Stimulus: offer one sample of -8192, then deassert `din_valid`.
  - Required: at the next boundary `underrun` = 1; bitstream continues with ones density ≈37.5%; `enable` low then high clears `underrun`.
- **Enable vs. valid collision.**
  - Stimulus: drop `enable` in the same cycle as `din_valid` = 1 at a boundary.
  - Required: `din_ready` = 0, no acceptance, IDLE on the next edge, `bit_valid` = 0 afterward.
- **Overload.**
  - Stimulus: `din` = +32767 for 2000 bits with INT_W=20.
  - Required: `overload` becomes 1 and stays 1; `bit_out` never X; `bit_valid` stays 1.
